// File: rtl/sap_pkg.sv
//------------------------------------------------------------------------------
// Module      : sap_pkg
// Description : Shared definitions for the parametrised SAP-style core:
//               opcode values, T-state ring indices and the sequencer
//               state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sap_pkg;

  // Opcode values, compared against the top OPW bits of the instruction word
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit positions of each T-state in the one-hot debug ring
  localparam int RING_W = 6;
  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;

  // Sequencer states: idle, the six ring T-states, and the sticky halt
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } state_t;

endpackage : sap_pkg

`default_nettype wire

// File: rtl/sap_ram.sv
//------------------------------------------------------------------------------
// Module      : sap_ram
// Description : 2**AW x DW program/data memory. Synchronous write,
//               asynchronous (combinational) read. Contents are not reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sap_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Single write port; the core muxes program loads and STA onto it
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : sap_ram

`default_nettype wire

// File: rtl/sap_core_p.sv
//------------------------------------------------------------------------------
// Module      : sap_core_p
// Description : Parametrised SAP-style accumulator CPU. Six-state ring
//               sequencer per instruction (fetch in T1..T3, execute in
//               T4..T6), internal loadable RAM, Z/C flags, OUT register
//               and debug taps.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sap_core_p
  import sap_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int OPW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          halted,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic [5:0]    ring,
  output logic          flag_z,
  output logic          flag_c
);

  // Architectural and sequencing registers
  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_mar;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_tmp;
  logic [DW-1:0] r_out;
  logic          r_out_valid;
  logic          r_halted;
  logic          r_z;
  logic          r_c;

  // Sequencer and decode wires
  state_t              w_state_nxt;
  logic [RING_W-1:0]   w_ring;
  logic                w_busy;
  logic [OPW-1:0]      w_opcode;
  logic [AW-1:0]       w_operand;
  logic [DW-1:0]       w_operand_ext;
  logic                w_op_lda;
  logic                w_op_add;
  logic                w_op_sub;
  logic                w_op_sta;
  logic                w_op_ldi;
  logic                w_op_jmp;
  logic                w_op_jz;
  logic                w_op_jc;
  logic                w_op_out;
  logic                w_op_hlt;
  logic                w_mem_op;

  // ALU wires; the extra MSB carries the carry-out / borrow
  logic [DW:0]         w_sum;
  logic [DW:0]         w_diff;

  // RAM port wires
  logic                w_ram_we;
  logic [AW-1:0]       w_ram_waddr;
  logic [DW-1:0]       w_ram_wdata;
  logic [DW-1:0]       w_ram_rdata;

  //----------------------------------------------------------------------------
  // Instruction decode
  //----------------------------------------------------------------------------
  assign w_opcode      = r_ir[DW-1 -: OPW];
  assign w_operand     = r_ir[AW-1:0];
  assign w_operand_ext = {{(DW-AW){1'b0}}, w_operand};

  assign w_op_lda = (w_opcode == OPW'(OP_LDA));
  assign w_op_add = (w_opcode == OPW'(OP_ADD));
  assign w_op_sub = (w_opcode == OPW'(OP_SUB));
  assign w_op_sta = (w_opcode == OPW'(OP_STA));
  assign w_op_ldi = (w_opcode == OPW'(OP_LDI));
  assign w_op_jmp = (w_opcode == OPW'(OP_JMP));
  assign w_op_jz  = (w_opcode == OPW'(OP_JZ));
  assign w_op_jc  = (w_opcode == OPW'(OP_JC));
  assign w_op_out = (w_opcode == OPW'(OP_OUT));
  assign w_op_hlt = (w_opcode == OPW'(OP_HLT));

  // Instructions that address memory through MAR in T4
  assign w_mem_op = w_op_lda | w_op_add | w_op_sub | w_op_sta;

  //----------------------------------------------------------------------------
  // ALU: acc op tmp, zero-extended by one bit to expose carry/borrow
  //----------------------------------------------------------------------------
  assign w_sum  = {1'b0, r_acc} + {1'b0, r_tmp};
  assign w_diff = {1'b0, r_acc} - {1'b0, r_tmp};

  //----------------------------------------------------------------------------
  // Sequencer
  //----------------------------------------------------------------------------

  // State register; clr returns the core to idle asynchronously
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, one-hot ring and busy decode
  always_comb begin
    w_state_nxt = r_state;
    w_ring      = '0;
    w_busy      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (run && !r_halted) begin
          w_state_nxt = ST_T1;
        end
      end
      ST_T1: begin
        w_ring[T1_IDX] = 1'b1;
        w_state_nxt    = ST_T2;
      end
      ST_T2: begin
        w_ring[T2_IDX] = 1'b1;
        w_busy         = 1'b1;
        w_state_nxt    = ST_T3;
      end
      ST_T3: begin
        w_ring[T3_IDX] = 1'b1;
        w_busy         = 1'b1;
        w_state_nxt    = ST_T4;
      end
      ST_T4: begin
        w_ring[T4_IDX] = 1'b1;
        w_busy         = 1'b1;
        w_state_nxt    = w_op_hlt ? ST_HALT : ST_T5;
      end
      ST_T5: begin
        w_ring[T5_IDX] = 1'b1;
        w_busy         = 1'b1;
        w_state_nxt    = ST_T6;
      end
      ST_T6: begin
        // run is only looked at on the instruction boundary, so a run
        // drop mid-instruction lets the instruction finish
        w_ring[T6_IDX] = 1'b1;
        w_busy         = 1'b1;
        w_state_nxt    = run ? ST_T1 : ST_IDLE;
      end
      ST_HALT: begin
        // Only clr leaves halt
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // RAM write arbitration
  //----------------------------------------------------------------------------

  // STA owns the port in T5; the program port is honoured only while the
  // core is idle or halted, when no instruction can be using the RAM
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = r_mar;
    w_ram_wdata = r_acc;
    if ((r_state == ST_T5) && w_op_sta) begin
      w_ram_we = 1'b1;
    end else if (prog_we && ((r_state == ST_IDLE) || (r_state == ST_HALT))) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = prog_addr;
      w_ram_wdata = prog_data;
    end
  end

  sap_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (r_mar),
    .o_rdata (w_ram_rdata)
  );

  //----------------------------------------------------------------------------
  // Datapath
  //----------------------------------------------------------------------------

  // Fetch (T1..T3) and execute (T4..T6) register transfers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_acc       <= '0;
      r_tmp       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
    end else begin
      // out_valid is a single-cycle pulse accompanying each OUT update
      r_out_valid <= 1'b0;
      unique case (r_state)
        ST_T1: begin
          r_mar <= r_pc;
        end
        ST_T2: begin
          r_pc <= r_pc + AW'(1);
        end
        ST_T3: begin
          r_ir <= w_ram_rdata;
        end
        ST_T4: begin
          if (w_mem_op) begin
            r_mar <= w_operand;
          end
          if (w_op_ldi) begin
            r_acc <= w_operand_ext;
          end
          if (w_op_jmp || (w_op_jz && r_z) || (w_op_jc && r_c)) begin
            r_pc <= w_operand;
          end
          if (w_op_out) begin
            r_out       <= r_acc;
            r_out_valid <= 1'b1;
          end
          if (w_op_hlt) begin
            r_halted <= 1'b1;
          end
        end
        ST_T5: begin
          if (w_op_lda) begin
            r_acc <= w_ram_rdata;
          end
          if (w_op_add || w_op_sub) begin
            r_tmp <= w_ram_rdata;
          end
        end
        ST_T6: begin
          // Flags change only here, and only for ADD/SUB
          if (w_op_add) begin
            r_acc <= w_sum[DW-1:0];
            r_c   <= w_sum[DW];
            r_z   <= (w_sum[DW-1:0] == '0);
          end else if (w_op_sub) begin
            r_acc <= w_diff[DW-1:0];
            r_c   <= w_diff[DW];
            r_z   <= (w_diff[DW-1:0] == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // Outputs
  //----------------------------------------------------------------------------
  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;
  assign busy      = w_busy;
  assign pc        = r_pc;
  assign acc       = r_acc;
  assign ring      = w_ring;
  assign flag_z    = r_z;
  assign flag_c    = r_c;

endmodule : sap_core_p

`default_nettype wire

// File: doc/sap_core_p.md
Name: sap_core_p

Overview:
- Parametrised successor to the team's 8-bit SAP-style accumulator CPU.
- Generalised data/address width, loadable internal program/data RAM, jump/branch, store, immediate-load and halt instructions, plus Z/C flags.
- Fixed 6-state ring sequencer per instruction.
- Sits at top level of the class-project datapath; drives output register and debug taps.

Parameters:
- DW, 8, data/bus width; must satisfy DW >= AW+4.
- AW, 4, address width; RAM depth 2**AW words of DW bits.
- OPW, 4, opcode field width; opcode = word[DW-1 -: OPW], operand = word[AW-1:0].

Ports:
- clk  in  1  system clock; all state on posedge.
- clr  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute, 0 = pause at instruction boundary.
- prog_we  in  1  RAM write strobe; honoured only while paused or halted.
- prog_addr  in  AW  RAM write address.
- prog_data  in  DW  RAM write data.
- out_data  out  DW  output register (OUT instruction).
- out_valid  out  1  one-cycle pulse when out_data updates.
- halted  out  1  sticky; set by HLT.
- busy  out  1  high while sequencer is in T2..T6.
- pc  out  AW  program counter (debug).
- acc  out  DW  accumulator (debug).
- ring  out  6  one-hot T-state (debug); 0 when idle/halted.
- flag_z, flag_c  out  1 each  zero / carry-borrow flags.

Behaviour:
- Reset (clr=0, async): pc, acc, out_data, flags, IR, MAR = 0; out_valid=0; halted=0; ring=0. RAM contents are not reset.
- States: IDLE (ring=0), T1..T6 (ring bit0..bit5), HALT.
- IDLE -> T1 on posedge when run=1 and halted=0. T6 -> T1 if run=1, else -> IDLE. A run drop mid-instruction completes the instruction.
- Per-instruction timing:
  - T1: MAR <= pc.
  - T2: pc <= pc+1 (mod 2**AW; 2**AW-1 wraps to 0).
  - T3: IR <= RAM[MAR].
  - T4..T6: execute. Next instruction starts exactly 6 cycles after the previous T1.
- Opcodes (operand n = IR[AW-1:0]; zero-extend to DW where needed):
  - 0 LDA: T4 MAR<=n; T5 acc<=RAM[n].
  - 1 ADD: T4 MAR<=n; T5 tmp<=RAM[n]; T6 {C,acc}<=acc+tmp; Z<=(acc==0).
  - 2 SUB: as ADD, acc<=acc-tmp (mod 2**DW); C<=1 iff borrow (acc<tmp).
  - 3 STA: T4 MAR<=n; T5 RAM[n]<=acc.
  - 4 LDI: T4 acc<=zero-extended n.
  - 5 JMP: T4 pc<=n.
  - 6 JZ: T4 pc<=n if Z.
  - 7 JC: T4 pc<=n if C.
  - E OUT: T4 out_data<=acc; out_valid=1 for that one cycle only.
  - F HLT: T4 halted<=1, state -> HALT; pc holds address after HLT.
  - Others: NOP; T4..T6 idle.
- Flags change only on ADD/SUB; all other instructions preserve them.
- HALT exits only via clr; run ignored.
- prog_we: write RAM[prog_addr] on posedge when state is IDLE or HALT; ignored otherwise. No read-during-write hazard exists, since the core does not read RAM in those states.
- STA to the executing location is legal; the new word is fetched next visit.
- out_valid is registered, coincident with the out_data update.

Decomposition:
- Package sap_pkg: opcode localparams (OP_LDA..OP_HLT), T-state index constants, state enum.
- Sub-module sap_ram: 2**AW x DW, synchronous write, asynchronous read. Two write sources, muxed in the core: program port and STA.
- Sequencer, decode and ALU stay inline in sap_core_p.

Test Plan:
- Load {0:LDA 9, 1:ADD A, 2:SUB B, 3:OUT, 4:HLT, 9:0x10, A:0x14, B:0x18}, run=1 -> out_data=0x0C with a single out_valid pulse at cycle 6*3+4 after the first T1; halted=1; flag_c=0.
- Program LDI F, ADD(mem=0xF5), JC 7, OUT, HLT, 7:OUT, HLT -> acc=0x04, C=1, branch taken, exactly one OUT of 0x04.
- LDI 3, SUB(mem=0x03), JZ 6, HLT, 6:STA E, LDA E, OUT, HLT -> Z=1 branch taken; RAM[E]=0, out_data=0; then SUB 0x01 from 0 -> acc=0xFF, C=1.
- Drop run during T3 -> instruction completes; ring=0 after T6; pc unchanged for 20 cycles. prog_we during pause writes RAM; prog_we during busy is ignored (readback via LDA/OUT).
- Assert clr at T5 of ADD -> all outputs zero immediately (async); RAM preserved; rerun reproduces the first result.
- AW=5, DW=10 instance: JMP 1F, then fall-through at 0x1F wraps pc to 0 -> pc sequence 1F->0 observed.
